// File: rtl/spi_target_regfile_if.sv
// Bundles the SPI target pins, the local register-file port and the SPI write
// notification. The slave modport is the register-file side.
interface spi_target_regfile_if #(parameter int ADDR_W = 4);
  logic              spi_cen;
  logic              spi_sclk;
  logic              spi_sio0_si_mosi;
  logic              spi_sio1_so_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0]        loc_wdata;
  logic              loc_we;
  logic [7:0]        loc_rdata;
  logic              spi_wr_valid;
  logic [ADDR_W-1:0] spi_wr_addr;

  modport master (
    output spi_cen, spi_sclk, spi_sio0_si_mosi, loc_addr, loc_wdata, loc_we,
    input  spi_sio1_so_miso, spi_miso_oe, loc_rdata, spi_wr_valid, spi_wr_addr
  );

  modport slave (
    input  spi_cen, spi_sclk, spi_sio0_si_mosi, loc_addr, loc_wdata, loc_we,
    output spi_sio1_so_miso, spi_miso_oe, loc_rdata, spi_wr_valid, spi_wr_addr
  );
endinterface

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target oversampled in clk, fronting a 2^ADDR_W byte register file shared with a local port.
// Define SPI_TARGET_STATUS_EN to return {4'hA, overflow, 3'b101} during the command byte.
module spi_target_regfile #(
  parameter int ADDR_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  spi_target_regfile_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cen_q, sclk_q;
  logic [1:0]        mosi_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        loc_rdata_q;
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              commit;
  logic [7:0]        rx_next;
  logic [7:0]        status;
  logic              cen_rise, cen_fall, sclk_rise, sclk_fall;

  assign cen_rise  =  cen_q[1]  & ~cen_q[2];
  assign cen_fall  = ~cen_q[1]  &  cen_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign rx_next   = {rx_q, mosi_q[1]};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    commit    = 1'b0;
    if (cen_rise) begin
      state_d   = IDLE;
      tx_d      = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cen_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = status;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = rx_next[7];
              ptr_d   = rx_next[ADDR_W-1:0];
              state_d = DATA;
            end
          end else if (sclk_fall) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && !rw_q) begin
              commit = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end
          end else if (sclk_fall) begin
            // Byte boundary: reads prefetch the next byte, writes drive zeros.
            if (bit_cnt_q == 3'd0 && rw_q) begin
              tx_d  = mem_q[ptr_q];
              ptr_d = ptr_q + 1'b1;
            end else if (bit_cnt_q == 3'd0) begin
              tx_d = '0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // cen sync resets low so a select held across reset is ignored until cen toggles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cen_q     <= '0;
      sclk_q    <= '0;
      mosi_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      cen_q     <= {cen_q[1:0], bus.spi_cen};
      sclk_q    <= {sclk_q[1:0], bus.spi_sclk};
      mosi_q    <= {mosi_q[0], bus.spi_sio0_si_mosi};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      wr_vld_q  <= commit;
      if (commit) wr_addr_q <= ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      loc_rdata_q <= '0;
    end else begin
      loc_rdata_q <= mem_q[bus.loc_addr];
      if (bus.loc_we && !(commit && bus.loc_addr == ptr_q)) mem_q[bus.loc_addr] <= bus.loc_wdata;
      if (commit) mem_q[ptr_q] <= rx_next;
    end
  end

`ifdef SPI_TARGET_STATUS_EN
  logic ovf_q, ovf_d;
  logic ptr_wrap;

  assign ptr_wrap = (state_q == DATA) && (&ptr_q) && (ptr_d == '0);
  assign status   = {4'hA, ovf_q, 3'b101};

  // Reported on the select that loads the status byte, then cleared.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && cen_fall) ovf_d = 1'b0;
    if (ptr_wrap) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`else
  assign status = 8'h00;
`endif

  assign bus.spi_sio1_so_miso = tx_q[7];
  assign bus.spi_miso_oe      = (state_q != IDLE);
  assign bus.loc_rdata        = loc_rdata_q;
  assign bus.spi_wr_valid     = wr_vld_q;
  assign bus.spi_wr_addr      = wr_addr_q;
endmodule

// File: tb/tb_spi_target_regfile.sv
// Random and directed SPI/local traffic against a byte-array reference model; a negedge
// monitor pops expected write notifications, MISO bytes and local read data from queues.
module tb_spi_target_regfile;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_target_regfile_if #(.ADDR_W(AW)) bus();
  spi_target_regfile #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [7:0]    model [DEPTH];
  logic          ovf_m;
  logic [7:0]    burst [$];
  logic [AW-1:0] exp_wr_q [$];
  logic [7:0]    exp_miso_q [$];
  logic [7:0]    got_miso_q [$];
  logic [7:0]    exp_rd_q [$];
  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_wr_valid) begin
        if (exp_wr_q.size() == 0) chk("unexpected_wr_valid", 1, 0);
        else chk("wr_addr", 32'(bus.spi_wr_addr), 32'(exp_wr_q.pop_front()));
      end
      while (got_miso_q.size() > 0) begin
        if (exp_miso_q.size() == 0) begin
          chk("unexpected_miso_byte", 32'(got_miso_q.pop_front()), 32'hFFFF_FFFF);
        end else begin
          chk("miso_byte", 32'(got_miso_q.pop_front()), 32'(exp_miso_q.pop_front()));
        end
      end
      if (rd_pend) begin
        if (exp_rd_q.size() == 0) chk("unexpected_loc_read", 1, 0);
        else chk("loc_rdata", 32'(bus.loc_rdata), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  function automatic logic [7:0] status_m();
`ifdef SPI_TARGET_STATUS_EN
    return {4'hA, ovf_m, 3'b101};
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data set while sclk low, target sampled by us at the rising edge.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int b = 7; b >= 8 - nbits; b--) begin
      bus.spi_sio0_si_mosi = tx[b];
      tick(8);
      bus.spi_sclk = 1'b1;
      rx[b] = bus.spi_sio1_so_miso;
      tick(8);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic select_cmd(input logic [7:0] cmd);
    logic [7:0] rx;
    exp_miso_q.push_back(status_m());
    ovf_m = 1'b0;
    bus.spi_cen = 1'b0;
    tick(8);
    spi_byte(cmd, 8, rx);
    got_miso_q.push_back(rx);
  endtask

  task automatic deselect();
    tick(8);
    bus.spi_cen = 1'b1;
    tick(10);
  endtask

  task automatic spi_write(input logic [7:0] cmd);
    logic [7:0]    rx;
    logic [AW-1:0] p;
    p = cmd[AW-1:0];
    select_cmd(cmd);
    foreach (burst[i]) begin
      exp_miso_q.push_back(8'h00);
      exp_wr_q.push_back(p);
      model[p] = burst[i];
      if (&p) ovf_m = 1'b1;
      p = p + 1'b1;
      spi_byte(burst[i], 8, rx);
      got_miso_q.push_back(rx);
    end
    deselect();
  endtask

  // n data bytes plus the prefetch at the final fall advance the pointer n+1 times.
  task automatic spi_read(input logic [7:0] cmd, input int n);
    logic [7:0]    rx;
    logic [AW-1:0] p;
    p = cmd[AW-1:0];
    select_cmd(cmd);
    for (int i = 0; i < n; i++) begin
      exp_miso_q.push_back(model[p]);
      if (&p) ovf_m = 1'b1;
      p = p + 1'b1;
      spi_byte(8'($urandom), 8, rx);
      got_miso_q.push_back(rx);
    end
    if (&p) ovf_m = 1'b1;
    deselect();
  endtask

  task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.loc_addr = a; bus.loc_wdata = d; bus.loc_we = 1'b1;
    tick(1);
    bus.loc_we = 1'b0;
    model[a] = d;
  endtask

  task automatic loc_read(input logic [AW-1:0] a);
    bus.loc_addr = a;
    exp_rd_q.push_back(model[a]);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    tick(1);
  endtask

  task automatic collide(input logic [AW-1:0] la, input logic [7:0] spi_dat);
    bit seen;
    seen = 1'b0;
    burst.delete();
    burst.push_back(spi_dat);
    fork
      spi_write(8'h02);
      begin
        bus.loc_addr = la; bus.loc_wdata = 8'hFF; bus.loc_we = 1'b1;
        for (int k = 0; k < 3000 && !seen; k++) begin
          tick(1);
          if (bus.spi_wr_valid) seen = 1'b1;
        end
        bus.loc_we = 1'b0;
      end
    join
    chk("collision_wr_seen", 32'(seen), 1);
    if (la != 2) model[la] = 8'hFF;
  endtask

  initial begin
    logic [7:0]    rx, c, d;
    logic [AW-1:0] a;
    int            n;

    rst = 1'b1;
    bus.spi_cen = 1'b1; bus.spi_sclk = 1'b0; bus.spi_sio0_si_mosi = 1'b0;
    bus.loc_addr = '0; bus.loc_wdata = '0; bus.loc_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    ovf_m = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_miso", 32'(bus.spi_sio1_so_miso), 0);
    chk("rst_oe", 32'(bus.spi_miso_oe), 0);
    chk("rst_wr_valid", 32'(bus.spi_wr_valid), 0);
    chk("rst_wr_addr", 32'(bus.spi_wr_addr), 0);
    chk("rst_loc_rdata", 32'(bus.loc_rdata), 0);
    tick(5);

    // Write burst 0x11,0x22 at address 3.
    burst = '{8'h11, 8'h22};
    spi_write(8'h03);
    loc_read(4'd4);
    loc_read(4'd3);

    // Read with wrap from 0xF to 0x0.
    loc_write(4'hF, 8'h5A);
    spi_read(8'h8F, 2);

    // Abort after 5 bits of a data byte.
    select_cmd(8'h06);
    spi_byte(8'hE7, 5, rx);
    bus.spi_cen = 1'b1;
    tick(4);
    chk("abort_oe", 32'(bus.spi_miso_oe), 0);
    chk("abort_miso", 32'(bus.spi_sio1_so_miso), 0);
    tick(10);
    loc_read(4'd6);

    // Same-cycle commit: same address then different address.
    collide(4'd2, 8'h3C);
    loc_read(4'd2);
    collide(4'd5, 8'h77);
    loc_read(4'd2);
    loc_read(4'd5);

    // 17-byte burst wraps the pointer; next two selects report status.
    burst.delete();
    for (int i = 0; i < 17; i++) burst.push_back(8'($urandom));
    spi_write(8'h00);
    spi_read(8'h80, 1);
    spi_read(8'h80, 1);

    // Randomized mix.
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          burst.delete();
          n = $urandom_range(1, 4);
          for (int k = 0; k < n; k++) burst.push_back(8'($urandom));
          c = 8'($urandom); c[7] = 1'b0;
          spi_write(c);
        end
        1: begin
          c = 8'($urandom); c[7] = 1'b1;
          spi_read(c, $urandom_range(1, 3));
        end
        2: begin
          a = 4'($urandom_range(0, 15)); d = 8'($urandom);
          loc_write(a, d);
        end
        default: loc_read(4'($urandom_range(0, 15)));
      endcase
    end
    for (int i = 0; i < DEPTH; i++) loc_read(4'(i));

    // Reset during the data phase of a write burst; cen stays low afterwards.
    select_cmd(8'h00);
    exp_miso_q.push_back(8'h00);
    exp_wr_q.push_back(4'd0);
    spi_byte(8'h99, 8, rx);
    got_miso_q.push_back(rx);
    spi_byte(8'hC3, 4, rx);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    ovf_m = 1'b0;
    tick(1);
    chk("midrst_oe", 32'(bus.spi_miso_oe), 0);
    chk("midrst_miso", 32'(bus.spi_sio1_so_miso), 0);
    chk("midrst_wr_addr", 32'(bus.spi_wr_addr), 0);
    chk("midrst_loc_rdata", 32'(bus.loc_rdata), 0);
    spi_byte(8'h01, 8, rx);
    spi_byte(8'h55, 8, rx);
    chk("held_cen_oe", 32'(bus.spi_miso_oe), 0);
    deselect();
    for (int i = 0; i < DEPTH; i++) loc_read(4'(i));
    burst = '{8'hA7};
    spi_write(8'h09);
    loc_read(4'd9);

    tick(20);
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 0);
    chk("miso_queue_drained", 32'(exp_miso_q.size()), 0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
